video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Synthesizable raster video source that drives the `invs`/`inde`/`indata` stream consumed by the window-tap pipeline. It generates frame and line timing from the same width/blanking parameters the tap uses and fills active pixels with a selectable test pattern. It is the on-chip stimulus and bring-up source at the head of the video chain, and drives the tap directly with no intermediate buffering.

## Interface
- `DSIZE`, 24, pixel width; multiple of 3 (three equal channels, MSB channel first)
- `VIDEO_WIDTH`, 1920, active pixels per line; multiple of 8
- `VIDEO_PRE_WIDTH`, 280, blanking pixels per line, placed before active pixels
- `VIDEO_HEIGHT`, 1080, active lines per frame
- `VIDEO_PRE_HEIGHT`, 45, blanking lines per frame, placed before active lines
- `VS_LINES`, 5, lines of `outvs` high at frame start; 1 ≤ VS_LINES ≤ VIDEO_PRE_HEIGHT
- `clock`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  run request; level-sensitive
- `pattern`  in  2  0 ramp, 1 colour bars, 2 checkerboard, 3 frame count
- `outvs`  out  1  frame sync, active-high
- `outde`  out  1  active pixel valid
- `outdata`  out  DSIZE  pixel; 0 whenever `outde`=0
- `frame_done`  out  1  one-cycle pulse coincident with the last active pixel of a frame

## Operation
- State machine: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0 and all outputs 0. `enable`=1 → RUN.
  - RUN: `hcnt` counts 0..VIDEO_WIDTH+VIDEO_PRE_WIDTH-1 and wraps. On wrap, `vcnt` counts 0..VIDEO_HEIGHT+VIDEO_PRE_HEIGHT-1 and wraps. `enable`=0 → DRAIN.
  - DRAIN: counting continues. On the frame's final cycle (both counters at max), go to IDLE. If `enable` returns to 1 first, go back to RUN. Frames are never truncated.
- Decode from counters:
  - vs = (vcnt < VS_LINES)
  - de = (vcnt ≥ VIDEO_PRE_HEIGHT) && (hcnt ≥ VIDEO_PRE_WIDTH)
  - x = hcnt − VIDEO_PRE_WIDTH
  - y = vcnt − VIDEO_PRE_HEIGHT
- `pattern` is latched only when hcnt=vcnt=0. A mid-frame change takes effect on the next frame.
- Pixel formulas (C = DSIZE/3):
  - Ramp: x zero-extended or truncated to DSIZE.
  - Colour bars: bar index b (0..7) steps every VIDEO_WIDTH/8 active pixels. It comes from a bar counter, with no divider. Channel k (k=2 MSB) is all-ones if b[k], else 0. b resets to 0 at each line start.
  - Checkerboard: all-ones if x[3]^y[3], else 0.
  - Frame count: 8-bit `fcnt` zero-extended/truncated to DSIZE. `fcnt` increments when hcnt=vcnt=0 in RUN/DRAIN, wraps 255→0, and is cleared only by `rst`.
- `frame_done` = de on the pixel with x=VIDEO_WIDTH−1, y=VIDEO_HEIGHT−1.

## Timing
- All outputs are registered and lag the counters by exactly 1 cycle.
- `enable` is sampled high in IDLE at edge N. The state is RUN with hcnt=vcnt=0 after edge N+1. `outvs` rises after edge N+2.
- The first `outde` of a frame occurs VIDEO_PRE_HEIGHT·(VIDEO_WIDTH+VIDEO_PRE_WIDTH)+VIDEO_PRE_WIDTH cycles after `outvs` rises.
- Frame period is (VIDEO_WIDTH+VIDEO_PRE_WIDTH)·(VIDEO_HEIGHT+VIDEO_PRE_HEIGHT) cycles, with no gaps between frames while enabled.
- `rst` asserted at any time, including mid-frame: state, all counters, `fcnt`, and latched pattern go to 0 immediately. All outputs read 0 from that instant.
- `enable` toggling 1→0→1 within one frame does not disturb timing.

## Structure
- Shared package `video_tap_pkg`: state encoding (IDLE/RUN/DRAIN) and pattern codes (PAT_RAMP, PAT_BARS, PAT_CHECK, PAT_FCNT). The tap-side blocks use the same package.
- One sub-module `video_timing_cnt`: `hcnt`/`vcnt` counters with wrap flags and a `run` input. The top level holds the FSM, pattern logic and output registers.

## Test plan
Small-frame parameters: DSIZE=24, VIDEO_WIDTH=8, VIDEO_PRE_WIDTH=4, VIDEO_HEIGHT=4, VIDEO_PRE_HEIGHT=2, VS_LINES=1. This gives 12-cycle lines and a 72-cycle frame.
1. Reset, then `enable`=1, `pattern`=0 → `outvs` high 12 cycles; first `outde` 28 cycles after `outvs` rises; each line gives `outdata` 0..7 with `outde`; 32 `outde` cycles per frame; `frame_done` exactly once, on the pixel with x=7, y=3.
2. `pattern`=1 → per line, `outdata` is 0x000000 ×1, 0x0000FF ×1, 0x00FF00 ×1, …, 0xFFFFFF ×1; b returns to 0 on the next line.
3. `pattern`=3, 3 frames → `outdata`=1, 2, 3 in successive frames. Change `pattern` 0→3 mid-frame → ramp continues to frame end, and the new pattern starts at the next frame.
4. Drop `enable` at cycle 20 of a frame → frame completes all 72 cycles, then IDLE with all outputs 0. Re-raise `enable` at cycle 40 → no IDLE, and the next frame follows back-to-back.
5. Assert `rst` mid-active-line → `outde`, `outvs`, `outdata`, `frame_done` are 0 immediately. After release with `enable`=1, the `fcnt` pattern restarts at 1.
6. Run 2 frames with `pattern`=2 → `outdata` toggles 0/0xFFFFFF every 8 pixels and flips phase every 8 lines. This needs VIDEO_WIDTH=16, VIDEO_HEIGHT=16 for the check.

Source files
------------

// File: rtl/video_tap_pkg.sv
// ---------------------------------------------------------------------------
// video_tap_pkg
// Definitions shared by the pattern generator and the tap-side blocks:
//   state_t            : run-control state encoding (IDLE / RUN / DRAIN)
//   PAT_*              : test-pattern selector codes
// ---------------------------------------------------------------------------
package video_tap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_FCNT  = 2'd3;

endpackage

// File: rtl/video_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// video_pattern_gen_if
// Control inputs and raster output stream of the pattern generator.
//   enable, pattern                       : run request and pattern select
//   outvs, outde, outdata, frame_done     : raster stream towards the tap
// modport master : the generator (drives the stream)
// modport slave  : controller / consumer side
// ---------------------------------------------------------------------------
interface video_pattern_gen_if #(
    parameter int DSIZE = 24
);
    logic             enable;
    logic [1:0]       pattern;
    logic             outvs;
    logic             outde;
    logic [DSIZE-1:0] outdata;
    logic             frame_done;

    modport master (
        input  enable, pattern,
        output outvs, outde, outdata, frame_done
    );

    modport slave (
        output enable, pattern,
        input  outvs, outde, outdata, frame_done
    );
endinterface

// File: rtl/video_timing_cnt.sv
// ---------------------------------------------------------------------------
// video_timing_cnt
// Horizontal / vertical raster counters.
//   clock, rst  : clock, asynchronous active-high reset
//   run         : count when high, hold both counters at 0 when low
//   hcnt, vcnt  : current position inside the total (blanking + active) frame
//   line_wrap   : hcnt at its last value
//   frame_wrap  : hcnt and vcnt both at their last value
// ---------------------------------------------------------------------------
module video_timing_cnt #(
    parameter int H_TOTAL = 2200,
    parameter int V_TOTAL = 1125,
    parameter int HW      = 12,
    parameter int VW      = 11
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          run,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          line_wrap,
    output logic          frame_wrap
);
    logic [HW-1:0] hcnt_reg;
    logic [VW-1:0] vcnt_reg;

    assign hcnt       = hcnt_reg;
    assign vcnt       = vcnt_reg;
    assign line_wrap  = (hcnt_reg == HW'(H_TOTAL - 1));
    assign frame_wrap = line_wrap && (vcnt_reg == VW'(V_TOTAL - 1));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (!run) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (line_wrap) begin
            hcnt_reg <= '0;
            vcnt_reg <= frame_wrap ? '0 : vcnt_reg + 1'b1;
        end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
// Raster test-pattern source feeding the window-tap pipeline.
//   clock, rst : clock, asynchronous active-high reset
//   vid        : master side of video_pattern_gen_if
//                (enable/pattern in; outvs/outde/outdata/frame_done out)
// Frames always run to completion once started; all stream outputs are
// registered one cycle behind the raster counters.
// ---------------------------------------------------------------------------
module video_pattern_gen
    import video_tap_pkg::*;
#(
    parameter int DSIZE            = 24,
    parameter int VIDEO_WIDTH      = 1920,
    parameter int VIDEO_PRE_WIDTH  = 280,
    parameter int VIDEO_HEIGHT     = 1080,
    parameter int VIDEO_PRE_HEIGHT = 45,
    parameter int VS_LINES         = 5
) (
    input  logic                clock,
    input  logic                rst,
    video_pattern_gen_if.master vid
);
    localparam int H_TOTAL  = VIDEO_WIDTH + VIDEO_PRE_WIDTH;
    localparam int V_TOTAL  = VIDEO_HEIGHT + VIDEO_PRE_HEIGHT;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int C        = DSIZE / 3;
    localparam int BAR_STEP = VIDEO_WIDTH / 8;
    localparam int SUB_W    = (BAR_STEP > 1) ? $clog2(BAR_STEP) : 1;

    state_t           state_reg, state_next;
    logic             enable_reg;
    logic [1:0]       pattern_reg;
    logic [7:0]       fcnt_reg;
    logic [SUB_W-1:0] bar_sub_reg;
    logic [2:0]       bar_idx_reg;
    logic             outvs_reg, outde_reg, frame_done_reg;
    logic [DSIZE-1:0] outdata_reg;

    logic          run;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          line_wrap, frame_wrap;
    logic          frame_start, vs, de;
    logic [15:0]   x_pos;
    logic [3:0]    y_low;
    logic [DSIZE-1:0] pixel;

    assign run = (state_reg != ST_IDLE);

    video_timing_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_timing (
        .clock      (clock),
        .rst        (rst),
        .run        (run),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .line_wrap  (line_wrap),
        .frame_wrap (frame_wrap)
    );

    assign frame_start = run && (hcnt == '0) && (vcnt == '0);
    assign vs          = (vcnt < VW'(VS_LINES));
    assign de          = (vcnt >= VW'(VIDEO_PRE_HEIGHT)) && (hcnt >= HW'(VIDEO_PRE_WIDTH));
    assign x_pos       = 16'(hcnt) - 16'(VIDEO_PRE_WIDTH);
    // Only bit 3 of y is ever needed (checkerboard phase).
    assign y_low       = 4'(16'(vcnt) - 16'(VIDEO_PRE_HEIGHT));

    // Enable is registered first, so RUN begins one edge after it is seen
    // and the counters are guaranteed to start from 0.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            enable_reg <= 1'b0;
            state_reg  <= ST_IDLE;
        end else begin
            enable_reg <= vid.enable;
            state_reg  <= state_next;
        end
    end

    // Dropping enable on the very last cycle of a frame stops right there
    // instead of draining a whole further frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (enable_reg) state_next = ST_RUN;
            ST_RUN:   if (!enable_reg) state_next = frame_wrap ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (enable_reg)      state_next = ST_RUN;
                else if (frame_wrap) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Pattern select and frame counter update only at the frame origin.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pattern_reg <= PAT_RAMP;
            fcnt_reg    <= '0;
        end else if (frame_start) begin
            pattern_reg <= vid.pattern;
            fcnt_reg    <= fcnt_reg + 8'd1;
        end
    end

    // Bar index tracks the pixel the counters currently point at: held at 0
    // through blanking, then advanced every BAR_STEP active pixels. The
    // 3-bit index rolls 7->0 on the last active pixel of the line.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            bar_sub_reg <= '0;
            bar_idx_reg <= '0;
        end else if (!run || line_wrap || (hcnt < HW'(VIDEO_PRE_WIDTH))) begin
            bar_sub_reg <= '0;
            bar_idx_reg <= '0;
        end else if (bar_sub_reg == SUB_W'(BAR_STEP - 1)) begin
            bar_sub_reg <= '0;
            bar_idx_reg <= bar_idx_reg + 3'd1;
        end else begin
            bar_sub_reg <= bar_sub_reg + 1'b1;
        end
    end

    always_comb begin
        pixel = '0;
        case (pattern_reg)
            PAT_RAMP:  pixel = DSIZE'(x_pos);
            PAT_BARS:  pixel = {{C{bar_idx_reg[2]}}, {C{bar_idx_reg[1]}}, {C{bar_idx_reg[0]}}};
            PAT_CHECK: pixel = {DSIZE{x_pos[3] ^ y_low[3]}};
            PAT_FCNT:  pixel = DSIZE'(fcnt_reg);
            default:   pixel = '0;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            outvs_reg      <= 1'b0;
            outde_reg      <= 1'b0;
            outdata_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            outvs_reg      <= run && vs;
            outde_reg      <= run && de;
            outdata_reg    <= (run && de) ? pixel : '0;
            // The frame's final counter position is exactly the last active pixel.
            frame_done_reg <= run && frame_wrap;
        end
    end

    assign vid.outvs      = outvs_reg;
    assign vid.outde      = outde_reg;
    assign vid.outdata    = outdata_reg;
    assign vid.frame_done = frame_done_reg;
endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
// Self-checking bench: directed phases followed by randomized enable/pattern
// segments, compared every cycle against a frame-position reference model.
// ---------------------------------------------------------------------------
module tb_video_pattern_gen;
    localparam int DSIZE = 24;
    localparam int W     = 16;
    localparam int PRE_W = 4;
    localparam int H     = 16;
    localparam int PRE_H = 2;
    localparam int VS    = 1;
    localparam int LINE  = W + PRE_W;
    localparam int FRAME = LINE * (H + PRE_H);

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    video_pattern_gen_if #(.DSIZE(DSIZE)) vif ();

    video_pattern_gen #(
        .DSIZE            (DSIZE),
        .VIDEO_WIDTH      (W),
        .VIDEO_PRE_WIDTH  (PRE_W),
        .VIDEO_HEIGHT     (H),
        .VIDEO_PRE_HEIGHT (PRE_H),
        .VS_LINES         (VS)
    ) dut (
        .clock (clk),
        .rst   (rst),
        .vid   (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DSIZE-1:0] ref_pixel(input int pat, input int x, input int y, input int f);
        int b;
        case (pat)
            0: return DSIZE'(x);
            1: begin
                b = x / (W / 8);
                return {((b >> 2) & 1) ? 8'hFF : 8'h00,
                        ((b >> 1) & 1) ? 8'hFF : 8'h00,
                        (b & 1)        ? 8'hFF : 8'h00};
            end
            2: return (((x / 8) + (y / 8)) % 2 == 1) ? {DSIZE{1'b1}} : '0;
            default: return DSIZE'(f);
        endcase
    endfunction

    bit               m_run = 0, m_en_d = 0;
    int               m_pos = 0, m_fcnt = 0, m_pat = 0;
    logic             e_vs = 0, e_de = 0, e_fd = 0;
    logic [DSIZE-1:0] e_data = '0;

    // m_pos is the position inside the frame (0..FRAME-1) the raster is at
    // before the edge; expected outputs after the edge describe that position.
    initial begin
        int row, col, x, y;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 0; m_en_d = 0; m_pos = 0; m_fcnt = 0; m_pat = 0;
                e_vs = 0; e_de = 0; e_fd = 0; e_data = '0;
            end else begin
                if (m_run && m_pos == 0) begin
                    m_fcnt = (m_fcnt + 1) % 256;
                    m_pat  = int'(vif.pattern);
                end
                if (m_run) begin
                    row    = m_pos / LINE;
                    col    = m_pos % LINE;
                    x      = col - PRE_W;
                    y      = row - PRE_H;
                    e_vs   = (row < VS);
                    e_de   = (row >= PRE_H) && (col >= PRE_W);
                    e_data = e_de ? ref_pixel(m_pat, x, y, m_fcnt) : '0;
                    e_fd   = e_de && (x == W - 1) && (y == H - 1);
                end else begin
                    e_vs = 0; e_de = 0; e_fd = 0; e_data = '0;
                end
                if (!m_run) begin
                    if (m_en_d) begin
                        m_run = 1;
                        m_pos = 0;
                    end
                end else if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    m_run = m_en_d;
                end else begin
                    m_pos++;
                end
                m_en_d = vif.enable;
            end
        end
    end

    // Cycle-by-cycle comparison of the whole output stream.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst)
                check("stream{vs,de,fd,data}",
                      64'({vif.outvs, vif.outde, vif.frame_done, vif.outdata}),
                      64'({e_vs, e_de, e_fd, e_data}));
        end
    end

    // Per-frame statistics: sync-to-first-pixel latency, pixels and
    // frame_done pulses per frame.
    initial begin
        bit prev_vs = 0, valid = 0, seen_de = 0;
        int de_cnt = 0, fd_cnt = 0, since_vs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vs = 0; valid = 0; seen_de = 0;
                de_cnt = 0; fd_cnt = 0; since_vs = 0;
            end else begin
                if (vif.outvs && !prev_vs) begin
                    if (valid) begin
                        check("de_per_frame", 64'(de_cnt), 64'(W * H));
                        check("frame_done_per_frame", 64'(fd_cnt), 64'd1);
                    end
                    valid = 1; seen_de = 0; de_cnt = 0; fd_cnt = 0; since_vs = 0;
                end
                if (vif.outde) begin
                    if (valid && !seen_de) begin
                        check("vs_to_first_de", 64'(since_vs), 64'(PRE_H * LINE + PRE_W));
                        seen_de = 1;
                    end
                    de_cnt++;
                end
                if (vif.frame_done) fd_cnt++;
                since_vs++;
                prev_vs = vif.outvs;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_de();
        int k = 0;
        while (vif.outde !== 1'b1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check("wait_de", 64'(vif.outde), 64'd1);
    endtask

    task automatic wait_vs_rise();
        int k = 0;
        while (vif.outvs !== 1'b0 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        while (vif.outvs !== 1'b1 && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check("wait_vs", 64'(vif.outvs), 64'd1);
    endtask

    initial begin
        rst         = 1'b1;
        vif.enable  = 1'b0;
        vif.pattern = 2'd0;
        wait_cycles(3);
        check("reset_outputs", 64'({vif.outvs, vif.outde, vif.frame_done, vif.outdata}), 64'd0);
        rst = 1'b0;

        // ramp, two back-to-back frames
        vif.enable = 1'b1;
        wait_cycles(2 * FRAME);
        // colour bars
        vif.pattern = 2'd1;
        wait_cycles(FRAME);
        // frame count over three frames
        vif.pattern = 2'd3;
        wait_cycles(3 * FRAME);
        // mid-frame pattern change only takes effect at the next frame
        vif.pattern = 2'd0;
        wait_cycles(FRAME + 100);
        vif.pattern = 2'd3;
        wait_cycles(FRAME);
        // checkerboard
        vif.pattern = 2'd2;
        wait_cycles(2 * FRAME);

        // enable dropped at cycle 20, restored at cycle 40: no gap
        wait_vs_rise();
        wait_cycles(19);
        vif.enable = 1'b0;
        wait_cycles(20);
        vif.enable = 1'b1;
        wait_cycles(2 * FRAME);

        // enable dropped: frame finishes, then idle
        vif.enable = 1'b0;
        wait_cycles(2 * FRAME);

        // reset in the middle of an active line
        vif.enable  = 1'b1;
        vif.pattern = 2'd3;
        wait_de();
        #2 rst = 1'b1;
        #1;
        check("rst_outvs", 64'(vif.outvs), 64'd0);
        check("rst_outde", 64'(vif.outde), 64'd0);
        check("rst_outdata", 64'(vif.outdata), 64'd0);
        check("rst_frame_done", 64'(vif.frame_done), 64'd0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2 * FRAME);

        // randomized enable / pattern segments
        for (int s = 0; s < 30; s++) begin
            vif.pattern = 2'($urandom_range(0, 3));
            vif.enable  = ($urandom_range(0, 3) != 0);
            wait_cycles($urandom_range(5, 300));
        end
        vif.enable = 1'b0;
        wait_cycles(2 * FRAME);
        wait_vs_rise_final();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // One last frame so the statistics monitor closes out the preceding one.
    task automatic wait_vs_rise_final();
        vif.enable = 1'b1;
        wait_vs_rise();
        wait_cycles(FRAME + 5);
        vif.enable = 1'b0;
        wait_cycles(FRAME + 5);
    endtask
endmodule
